// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter
// Two-port round-robin arbiter and command sequencer in front of the DDR
// SDRAM controller. A periodic refresh slot takes priority over both ports.
// All flops update on the falling edge of DDR_CLK so the controller sees
// commands change on negedge.
//
// Ports
//   DDR_CLK, RST            clock, synchronous active-high reset
//   Px_REQ/WR/BA/ADDR/WLEN  requester x command (held until DONE/ERR)
//   Px_GNT                  port x owns the controller (grant .. DONE/ABORT)
//   Px_DONE, Px_ERR         one-cycle completion / timeout pulses
//   COMMAND, BA_IN,         command to the controller, held until a
//   ADDR_IN, WRITE_LENGTH   rising edge on ACCEPTED
//   ACCEPTED                controller completion (0->1 edge counts)
//   REFRESH_REQ/ACK         refresh slot handshake
//   BUSY                    state is not IDLE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | arbitrate: refresh first, else round-robin between ports
// ISSUE    | command held, waiting for ACCEPTED rise or watchdog
// DONE     | DONE pulse cycle, grant still high
// ABORT    | ERR pulse cycle, grant still high
// REFRESH  | REFRESH_REQ held until REFRESH_ACK
//
// TIMEOUT_CYC must be at least 2; CNT_W must hold max(REFRESH_INT, TIMEOUT_CYC).
module ddr_port_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned REFRESH_INT = 1280,
  parameter int unsigned CNT_W       = 11
) (
  input  logic        DDR_CLK,
  input  logic        RST,
  input  logic        P0_REQ,
  input  logic        P0_WR,
  input  logic [1:0]  P0_BA,
  input  logic [22:0] P0_ADDR,
  input  logic        P0_WLEN,
  input  logic        P1_REQ,
  input  logic        P1_WR,
  input  logic [1:0]  P1_BA,
  input  logic [22:0] P1_ADDR,
  input  logic        P1_WLEN,
  output logic        P0_GNT,
  output logic        P1_GNT,
  output logic        P0_DONE,
  output logic        P1_DONE,
  output logic        P0_ERR,
  output logic        P1_ERR,
  output logic [1:0]  COMMAND,
  output logic [1:0]  BA_IN,
  output logic [22:0] ADDR_IN,
  output logic        WRITE_LENGTH,
  input  logic        ACCEPTED,
  output logic        REFRESH_REQ,
  input  logic        REFRESH_ACK,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_DONE, ST_ABORT, ST_REFRESH
  } state_t;

  localparam logic [CNT_W-1:0] REF_RELOAD =
    (REFRESH_INT == 0) ? '0 : CNT_W'(REFRESH_INT - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic              ref_pend_q, ref_pend_d;
  logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
  logic              acc_q, acc_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [1:0]        ba_q, ba_d;
  logic [22:0]       addr_q, addr_d;
  logic              wlen_q, wlen_d;
  logic              rreq_q, rreq_d;
  logic              busy_q, busy_d;

  logic              rise;
  logic              ref_expire;
  logic              ref_clear;
  logic              sel;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    to_cnt_d   = to_cnt_q;
    gnt_d      = gnt_q;
    done_d     = 2'b00;
    err_d      = 2'b00;
    cmd_d      = cmd_q;
    ba_d       = ba_q;
    addr_d     = addr_q;
    wlen_d     = wlen_q;
    rreq_d     = rreq_q;
    ref_clear  = 1'b0;
    sel        = 1'b0;
    acc_d      = ACCEPTED;
    rise       = ACCEPTED & ~acc_q;

    ref_expire = (REFRESH_INT != 0) && (ref_cnt_q == '0);
    if (REFRESH_INT == 0)
      ref_cnt_d = '0;
    else if (ref_expire)
      ref_cnt_d = REF_RELOAD;
    else
      ref_cnt_d = ref_cnt_q - CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (ref_pend_q) begin
          rreq_d  = 1'b1;
          state_d = ST_REFRESH;
        end else if (P0_REQ || P1_REQ) begin
          // On a tie the port that did not win last time goes next.
          sel      = (P0_REQ && P1_REQ) ? ~last_q : P1_REQ;
          cmd_d    = {(sel ? P1_WR : P0_WR), 1'b1};
          ba_d     = sel ? P1_BA : P0_BA;
          addr_d   = sel ? P1_ADDR : P0_ADDR;
          wlen_d   = sel ? P1_WLEN : P0_WLEN;
          gnt_d    = sel ? 2'b10 : 2'b01;
          last_d   = sel;
          to_cnt_d = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A rise in the watchdog's final cycle still completes normally.
        if (rise) begin
          cmd_d   = 2'b00;
          done_d  = gnt_q;
          state_d = ST_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          cmd_d   = 2'b00;
          err_d   = gnt_q;
          state_d = ST_ABORT;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
      end
      ST_DONE, ST_ABORT: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
      ST_REFRESH: begin
        if (REFRESH_ACK) begin
          rreq_d    = 1'b0;
          ref_clear = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An expiry coinciding with the ack keeps the new request; otherwise
    // at most one refresh is ever outstanding.
    ref_pend_d = ref_expire | (ref_pend_q & ~ref_clear);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(negedge DDR_CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      ref_cnt_q  <= REF_RELOAD;
      ref_pend_q <= 1'b0;
      to_cnt_q   <= '0;
      acc_q      <= 1'b0;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      cmd_q      <= 2'b00;
      ba_q       <= 2'b00;
      addr_q     <= '0;
      wlen_q     <= 1'b0;
      rreq_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      to_cnt_q   <= to_cnt_d;
      acc_q      <= acc_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cmd_q      <= cmd_d;
      ba_q       <= ba_d;
      addr_q     <= addr_d;
      wlen_q     <= wlen_d;
      rreq_q     <= rreq_d;
      busy_q     <= busy_d;
    end
  end

  assign P0_GNT       = gnt_q[0];
  assign P1_GNT       = gnt_q[1];
  assign P0_DONE      = done_q[0];
  assign P1_DONE      = done_q[1];
  assign P0_ERR       = err_q[0];
  assign P1_ERR       = err_q[1];
  assign COMMAND      = cmd_q;
  assign BA_IN        = ba_q;
  assign ADDR_IN      = addr_q;
  assign WRITE_LENGTH = wlen_q;
  assign REFRESH_REQ  = rreq_q;
  assign BUSY         = busy_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Bench for ddr_port_arbiter: directed scenarios followed by random traffic.
// Stimulus predicts each transaction (winner, command, outcome, ISSUE length)
// from the arbitration rules and queues it; a monitor compares the DUT
// against the queue head and an independent refresh schedule.
module tb_ddr_port_arbiter;
  localparam int TO = 8;
  localparam int RI = 20;

  logic        DDR_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        P0_REQ, P0_WR, P0_WLEN, P1_REQ, P1_WR, P1_WLEN;
  logic [1:0]  P0_BA, P1_BA;
  logic [22:0] P0_ADDR, P1_ADDR;
  logic        P0_GNT, P1_GNT, P0_DONE, P1_DONE, P0_ERR, P1_ERR;
  logic [1:0]  COMMAND, BA_IN;
  logic [22:0] ADDR_IN;
  logic        WRITE_LENGTH, ACCEPTED, REFRESH_REQ, REFRESH_ACK, BUSY;

  typedef struct {
    int          port;
    logic        err;
    logic [1:0]  cmd;
    logic [1:0]  ba;
    logic [22:0] addr;
    logic        wl;
    int          issue;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0, n_fail = 0;
  int          n_txn_exp = 0, n_txn_seen = 0, n_ref = 0;
  int          last_m = 1;
  logic        pend_r [2];
  logic        wr_a   [2];
  logic [1:0]  ba_a   [2];
  logic [22:0] addr_a [2];
  logic        wl_a   [2];

  ddr_port_arbiter #(.TIMEOUT_CYC(TO), .REFRESH_INT(RI), .CNT_W(11)) dut (
    .DDR_CLK(DDR_CLK), .RST(RST),
    .P0_REQ(P0_REQ), .P0_WR(P0_WR), .P0_BA(P0_BA), .P0_ADDR(P0_ADDR), .P0_WLEN(P0_WLEN),
    .P1_REQ(P1_REQ), .P1_WR(P1_WR), .P1_BA(P1_BA), .P1_ADDR(P1_ADDR), .P1_WLEN(P1_WLEN),
    .P0_GNT(P0_GNT), .P1_GNT(P1_GNT), .P0_DONE(P0_DONE), .P1_DONE(P1_DONE),
    .P0_ERR(P0_ERR), .P1_ERR(P1_ERR), .COMMAND(COMMAND), .BA_IN(BA_IN),
    .ADDR_IN(ADDR_IN), .WRITE_LENGTH(WRITE_LENGTH), .ACCEPTED(ACCEPTED),
    .REFRESH_REQ(REFRESH_REQ), .REFRESH_ACK(REFRESH_ACK), .BUSY(BUSY)
  );

  always #5 DDR_CLK = ~DDR_CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_ports();
    P0_REQ = pend_r[0]; P0_WR = wr_a[0]; P0_BA = ba_a[0]; P0_ADDR = addr_a[0]; P0_WLEN = wl_a[0];
    P1_REQ = pend_r[1]; P1_WR = wr_a[1]; P1_BA = ba_a[1]; P1_ADDR = addr_a[1]; P1_WLEN = wl_a[1];
  endtask

  task automatic raise(input int p, input logic wr, input logic [1:0] ba,
                       input logic [22:0] addr, input logic wl);
    pend_r[p] = 1'b1; wr_a[p] = wr; ba_a[p] = ba; addr_a[p] = addr; wl_a[p] = wl;
    drive_ports();
  endtask

  task automatic raise_rand(input int p);
    raise(p, 1'($urandom), 2'($urandom), 23'($urandom), 1'($urandom));
  endtask

  // Requester changes its command pins while it owns the controller.
  task automatic scramble(input int p);
    if (p == 0) begin
      P0_WR = 1'($urandom); P0_BA = 2'($urandom); P0_ADDR = 23'($urandom); P0_WLEN = 1'($urandom);
    end else begin
      P1_WR = 1'($urandom); P1_BA = 2'($urandom); P1_ADDR = 23'($urandom); P1_WLEN = 1'($urandom);
    end
  endtask

  task automatic predict(input int mode, input int d, output int w);
    exp_t e;
    w = (pend_r[0] && pend_r[1]) ? ((last_m == 0) ? 1 : 0) : (pend_r[0] ? 0 : 1);
    last_m = w;
    e.port  = w;
    e.err   = (mode == 1 || mode == 3);
    e.cmd   = {wr_a[w], 1'b1};
    e.ba    = ba_a[w];
    e.addr  = addr_a[w];
    e.wl    = wl_a[w];
    e.issue = e.err ? TO : d;
    exp_q.push_back(e);
    n_txn_exp++;
  endtask

  task automatic wait_grant();
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge DDR_CLK);
      got = P0_GNT | P1_GNT;
    end
    if (!got) chk("grant_wait", 0, 1);
  endtask

  // mode 0: ACCEPTED rises in ISSUE cycle d; 1: never; 2: stale high, drops
  // in cycle a, rises in cycle d; 3: stale high throughout.
  task automatic run_txn(input int mode, input int d, input int a);
    int w;
    bit got;
    predict(mode, d, w);
    if (mode >= 2) ACCEPTED = 1'b1;
    wait_grant();
    #1 scramble(w);
    if (mode == 0) begin
      repeat (d - 1) @(posedge DDR_CLK);
      #1 ACCEPTED = 1'b1;
    end else if (mode == 2) begin
      repeat (a - 1) @(posedge DDR_CLK);
      #1 ACCEPTED = 1'b0;
      repeat (d - a) @(posedge DDR_CLK);
      #1 ACCEPTED = 1'b1;
    end
    got = 0;
    for (int i = 0; i < TO + 4 && !got; i++) begin
      @(posedge DDR_CLK);
      got = P0_DONE | P1_DONE | P0_ERR | P1_ERR;
    end
    if (!got) chk("resp_wait", 0, 1);
    #1 pend_r[w] = 1'b0;
    ACCEPTED = 1'b0;
    drive_ports();
  endtask

  // Refresh issuer: acknowledges after a random delay.
  initial begin
    bit dropped;
    REFRESH_ACK = 1'b0;
    forever begin
      @(posedge DDR_CLK);
      if (REFRESH_REQ && !RST) begin
        repeat ($urandom_range(0, 3)) @(posedge DDR_CLK);
        #1 REFRESH_ACK = 1'b1;
        dropped = 0;
        for (int i = 0; i < 8 && !dropped; i++) begin
          @(posedge DDR_CLK);
          dropped = !REFRESH_REQ;
        end
        if (!dropped) chk("refresh_ack_ignored", 0, 1);
        #1 REFRESH_ACK = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit   prev_gnt, prev_busy, prev_pulse, prev_rreq, pend_m, pend_old, gnt_any, pulse, rfall;
    int   issue_n, edge_n, pend_age;
    logic [22:0] last_addr;
    exp_t h;
    prev_gnt = 0; prev_busy = 0; prev_pulse = 0; prev_rreq = 0; pend_m = 0;
    issue_n = 0; edge_n = 0; pend_age = 0; last_addr = '0;
    @(negedge DDR_CLK);
    forever begin
      @(posedge DDR_CLK);
      if (RST) begin
        chk("rst_command", COMMAND, 0);
        chk("rst_gnt", {P1_GNT, P0_GNT}, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_pulses", {P1_ERR, P0_ERR, P1_DONE, P0_DONE}, 0);
        chk("rst_refresh_req", REFRESH_REQ, 0);
        prev_gnt = 0; prev_busy = 0; prev_pulse = 0; prev_rreq = 0; pend_m = 0;
        issue_n = 0; edge_n = 0; pend_age = 0; last_addr = '0;
      end else begin
        // Refresh schedule: a request falls due every RI edges after reset.
        pend_old = pend_m;
        edge_n++;
        rfall  = prev_rreq && !REFRESH_REQ;
        pend_m = ((edge_n % RI) == 0) || (pend_m && !rfall);
        if (REFRESH_REQ && !prev_rreq) begin
          n_ref++;
          chk("refresh_when_pending", pend_old, 1);
          chk("refresh_latency", int'(pend_age <= 12), 1);
        end
        if (pend_m && !REFRESH_REQ) pend_age++; else pend_age = 0;
        if (pend_age == 13) chk("refresh_starved", 0, 1);

        gnt_any = P0_GNT | P1_GNT;
        pulse   = P0_DONE | P1_DONE | P0_ERR | P1_ERR;
        chk("gnt_exclusive", P0_GNT & P1_GNT, 0);
        chk("busy", BUSY, gnt_any | REFRESH_REQ);
        chk("refresh_vs_gnt", REFRESH_REQ & gnt_any, 0);

        if (gnt_any && !prev_gnt) begin
          issue_n = 0;
          if (exp_q.size() == 0) chk("unexpected_grant", 1, 0);
          else chk("grant_port", P1_GNT ? 1 : 0, exp_q[0].port);
          chk("idle_gap", prev_busy, 0);
          chk("grant_not_pending", pend_old, 0);
        end

        if (COMMAND != 2'b00) begin
          issue_n++;
          if (exp_q.size() == 0) chk("unexpected_command", 1, 0);
          else begin
            h = exp_q[0];
            chk("cmd", COMMAND, h.cmd);
            chk("ba", BA_IN, h.ba);
            chk("addr", ADDR_IN, h.addr);
            chk("wlen", WRITE_LENGTH, h.wl);
          end
        end

        if (pulse) begin
          n_txn_seen++;
          if (exp_q.size() == 0) chk("unexpected_response", 1, 0);
          else begin
            h = exp_q.pop_front();
            chk("resp_done", {P1_DONE, P0_DONE}, h.err ? 0 : (h.port == 1 ? 2 : 1));
            chk("resp_err", {P1_ERR, P0_ERR}, h.err ? (h.port == 1 ? 2 : 1) : 0);
            chk("issue_cycles", issue_n, h.issue);
            chk("cmd_idle_at_resp", COMMAND, 0);
            chk("gnt_during_resp", {P1_GNT, P0_GNT}, h.port == 1 ? 2 : 1);
            last_addr = h.addr;
          end
        end
        if (prev_pulse) begin
          chk("gnt_drop", gnt_any, 0);
          chk("addr_retained", ADDR_IN, last_addr);
        end

        prev_gnt = gnt_any; prev_busy = BUSY; prev_pulse = pulse; prev_rreq = REFRESH_REQ;
      end
    end
  end

  // Stimulus.
  initial begin
    int w;
    ACCEPTED = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pend_r[p] = 1'b0; wr_a[p] = 1'b0; ba_a[p] = '0; addr_a[p] = '0; wl_a[p] = 1'b0;
    end
    drive_ports();
    repeat (3) @(posedge DDR_CLK);
    #1 RST = 1'b0;

    // Contention: both held for four transactions, P0 first after reset.
    raise_rand(0); raise_rand(1);
    for (int k = 0; k < 4; k++) begin
      run_txn(0, k + 2, 0);
      if (k < 3) raise_rand(last_m);
    end
    run_txn(0, 1, 0);

    // Single write, accepted six cycles in.
    raise(0, 1'b1, 2'd2, 23'h12345, 1'b0);
    run_txn(0, 6, 0);

    // Watchdog, stale ACCEPTED, and rise in the watchdog's last cycle.
    raise_rand(0); run_txn(1, 0, 0);
    raise_rand(1); run_txn(2, 5, 2);
    raise_rand(0); run_txn(3, 0, 0);
    raise_rand(1); run_txn(0, TO, 0);

    // Reset while in ISSUE; no response may follow.
    raise_rand(0);
    predict(0, 4, w);
    wait_grant();
    repeat (2) @(posedge DDR_CLK);
    #1 RST = 1'b1;
    exp_q.delete();
    n_txn_exp--;
    pend_r[0] = 1'b0; pend_r[1] = 1'b0;
    ACCEPTED = 1'b0;
    drive_ports();
    last_m = 1;
    @(posedge DDR_CLK);
    #1 RST = 1'b0;
    repeat (3) @(posedge DDR_CLK);
    #1;
    raise_rand(0); raise_rand(1);
    run_txn(0, 3, 0);
    run_txn(0, 2, 0);

    // Random traffic.
    for (int it = 0; it < 150; it++) begin
      int mode, d, a, r;
      if ($urandom_range(0, 1) == 1) begin
        @(posedge DDR_CLK);
        #1;
      end
      for (int p = 0; p < 2; p++)
        if (!pend_r[p] && $urandom_range(0, 1) == 1) raise_rand(p);
      if (!pend_r[0] && !pend_r[1]) raise_rand($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      mode = (r <= 5) ? 0 : (r == 6) ? 1 : (r <= 8) ? 2 : 3;
      d = $urandom_range(1, TO);
      a = 0;
      if (mode == 2) begin
        d = $urandom_range(2, TO);
        a = $urandom_range(1, d - 1);
      end
      run_txn(mode, d, a);
    end
    while (pend_r[0] || pend_r[1]) run_txn(0, 2, 0);

    repeat (5) @(posedge DDR_CLK);
    chk("queue_drained", exp_q.size(), 0);
    chk("txn_count", n_txn_seen, n_txn_exp);
    chk("refresh_seen", int'(n_ref > 0), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
